// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer: channel count, select type
// and symbolic channel indices.
package demux_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2,
        CH_D = 2'd3
    } ch_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO for demux_4ch: extra-MSB pointers, head data read straight
// from storage, head_valid whenever the FIFO holds at least one entry.
module demux_chan_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit, so occupancy is their plain difference.
    assign count      = wr_ptr - rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr[AW-1:0]];

    // A full FIFO refuses the write even when it pops in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && head_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/demux_4ch.sv
// Registered 1-to-4 demultiplexer: one valid/ready stream steered by sel into
// four independently handshaked channel FIFOs (a, b, c, d).
module demux_4ch
    import demux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  sel_t              sel,
    input  logic              valid,
    output logic              ready,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  c,
    output logic [WIDTH-1:0]  d,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
);

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;
    logic [WIDTH-1:0]  head_data [NUM_CH];

    // Handshake: a beat transfers on any rising edge where valid && ready, on
    // the input and on every output channel alike; a producer holding valid
    // while ready is low keeps its data (and sel) stable until the transfer.
    // ready depends only on registered fullness, never on out_ready.
    assign ready = !full[sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign push[k] = valid && ready && (sel == sel_t'(k));

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (push[k]),
            .push_data  (in),
            .full       (full[k]),
            .pop        (out_ready[k]),
            .head_data  (head_data[k]),
            .head_valid (out_valid[k])
        );
    end

    assign a = head_data[CH_A];
    assign b = head_data[CH_B];
    assign c = head_data[CH_C];
    assign d = head_data[CH_D];

endmodule

// File: tb/tb_demux_4ch.sv
// Directed bench for demux_4ch: hand-computed checks per scenario plus a
// per-channel expected-queue scoreboard watching every pop.
module tb_demux_4ch;

    localparam int WIDTH = 2;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q [4][$];

    logic             prev_stall;
    logic [1:0]       prev_sel;
    logic [WIDTH-1:0] prev_in;

    demux_4ch #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .sel       (sel),
        .valid     (valid),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] head_of(input int k);
        case (k)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] x,
                         input logic [3:0] ordy);
        @(posedge clk);
        #1;
        valid     = v;
        sel       = s;
        din       = x;
        out_ready = ordy;
        #1;
    endtask

    // ---------------- scoreboard ----------------
    // Sampled mid-cycle: records the transfers the next rising edge will make.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            prev_stall = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("out_valid_ch%0d", k), 32'(out_valid[k]),
                      32'(exp_q[k].size() != 0));
            end
            check("ready_model", 32'(ready), 32'(exp_q[sel].size() < DEPTH));
            if (prev_stall && valid) begin
                check("hol_sel", 32'(sel), 32'(prev_sel));
                check("hol_in", 32'(din), 32'(prev_in));
            end
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k] && exp_q[k].size() != 0) begin
                    check($sformatf("pop_data_ch%0d", k), 32'(head_of(k)),
                          32'(exp_q[k].pop_front()));
                end
            end
            if (valid && ready) exp_q[sel].push_back(din);
            prev_stall = valid && !ready;
            prev_sel   = sel;
            prev_in    = din;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        valid      = 1'b1;
        sel        = 2'd2;
        din        = 2'd3;
        out_ready  = 4'h0;
        prev_stall = 1'b0;
        prev_sel   = '0;
        prev_in    = '0;

        // Reset held two cycles with valid high
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_a", 32'(a), 32'h0);
        check("rst_b", 32'(b), 32'h0);
        check("rst_c", 32'(c), 32'h0);
        check("rst_d", 32'(d), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        reset = 1'b1;
        valid = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 4'h0);
        check("post_rst_empty", 32'(out_valid), 32'h0);

        // Single route to c
        drive(1'b1, 2'd2, 2'b10, 4'hF);
        check("route_ready", 32'(ready), 32'h1);
        drive(1'b0, 2'd0, 2'd0, 4'hF);
        check("route_valid", 32'(out_valid), 32'b0100);
        check("route_c", 32'(c), 32'b10);
        drive(1'b0, 2'd0, 2'd0, 4'hF);
        check("route_drained", 32'(out_valid), 32'h0);

        // Fill channel a and backpressure
        drive(1'b1, 2'd0, 2'd1, 4'h0);
        check("fill_ready0", 32'(ready), 32'h1);
        drive(1'b1, 2'd0, 2'd2, 4'h0);
        check("fill_ready1", 32'(ready), 32'h1);
        check("fill_head1", 32'(a), 32'h1);
        drive(1'b1, 2'd0, 2'd3, 4'h0);
        check("fill_full", 32'(ready), 32'h0);
        drive(1'b1, 2'd0, 2'd3, 4'h0);
        check("fill_held", 32'(ready), 32'h0);
        drive(1'b1, 2'd0, 2'd3, 4'b0001);
        check("no_comb_path", 32'(ready), 32'h0);
        check("drain_a1", 32'(a), 32'h1);
        drive(1'b1, 2'd0, 2'd3, 4'b0001);
        check("ready_back", 32'(ready), 32'h1);
        check("drain_a2", 32'(a), 32'h2);
        drive(1'b0, 2'd0, 2'd0, 4'b0001);
        check("drain_a3", 32'(a), 32'h3);
        check("drain_a3_valid", 32'(out_valid), 32'b0001);
        drive(1'b0, 2'd0, 2'd0, 4'b0001);
        check("drain_a_empty", 32'(out_valid), 32'h0);

        // Channel independence: b full and stalled, d flowing
        drive(1'b1, 2'd1, 2'd1, 4'h0);
        drive(1'b1, 2'd1, 2'd2, 4'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd1, 2'd0, 4'b1000);
            check("indep_b_blocked", 32'(ready), 32'h0);
            if (i > 0) begin
                check("indep_d_valid", 32'(out_valid[3]), 32'h1);
                check("indep_d_data", 32'(d), 32'(i - 1));
            end
            drive(1'b1, 2'd3, WIDTH'(i), 4'b1000);
            check("indep_d_ready", 32'(ready), 32'h1);
        end
        drive(1'b0, 2'd0, 2'd0, 4'b1000);
        check("indep_d_last", 32'(d), 32'h3);
        check("indep_b_held", 32'(out_valid), 32'b1010);
        drive(1'b0, 2'd0, 2'd0, 4'b0010);
        check("indep_b1", 32'(b), 32'h1);
        drive(1'b0, 2'd0, 2'd0, 4'b0010);
        check("indep_b2", 32'(b), 32'h2);
        drive(1'b0, 2'd0, 2'd0, 4'b0000);
        check("indep_empty", 32'(out_valid), 32'h0);

        // Simultaneous push and pop on a, one entry resident
        drive(1'b1, 2'd0, 2'd0, 4'h0);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd0, WIDTH'(i), 4'b0001);
            check("pp_ready", 32'(ready), 32'h1);
            check("pp_valid", 32'(out_valid), 32'b0001);
            check("pp_head", 32'(a), 32'((i - 1) % 4));
        end
        drive(1'b0, 2'd0, 2'd0, 4'b0001);
        check("pp_tail", 32'(a), 32'h0);
        check("pp_tail_valid", 32'(out_valid), 32'b0001);
        drive(1'b0, 2'd0, 2'd0, 4'b0000);
        check("pp_empty", 32'(out_valid), 32'h0);

        // Reset mid-stream with a and c holding two entries
        drive(1'b1, 2'd0, 2'd1, 4'h0);
        drive(1'b1, 2'd0, 2'd2, 4'h0);
        drive(1'b1, 2'd2, 2'd3, 4'h0);
        drive(1'b1, 2'd2, 2'd0, 4'h0);
        drive(1'b0, 2'd0, 2'd0, 4'h0);
        check("mid_pre_valid", 32'(out_valid), 32'b0101);
        check("mid_pre_full", 32'(ready), 32'h0);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_valid", 32'(out_valid), 32'h0);
        check("mid_async_a", 32'(a), 32'h0);
        check("mid_async_c", 32'(c), 32'h0);
        check("mid_async_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 4'hF);
        check("mid_after_valid", 32'(out_valid), 32'h0);
        check("mid_after_a", 32'(a), 32'h0);
        drive(1'b1, 2'd1, 2'd2, 4'hF);
        check("mid_resume_ready", 32'(ready), 32'h1);
        drive(1'b0, 2'd0, 2'd0, 4'hF);
        check("mid_resume_valid", 32'(out_valid), 32'b0010);
        check("mid_resume_b", 32'(b), 32'h2);
        drive(1'b0, 2'd0, 2'd0, 4'hF);
        check("mid_resume_empty", 32'(out_valid), 32'h0);

        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_leftover_ch%0d", k), 32'(exp_q[k].size()), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_4ch.md
# demux_4ch

Registered 1-to-4 demultiplexer: the inverse of the team's 4-to-1 `mux`. A single valid/ready input stream is steered by `sel` into one of four output channels `a`–`d`, each buffered by its own small FIFO with an independent valid/ready handshake. It sits on the producer side of a `mux` instance, fanning one source out to four consumers, so a `mux` → `demux_4ch` pair round-trips data for loopback verification.

## Interface
- `WIDTH`, default 2: data width of `in` and of each of `a`, `b`, `c`, `d`.
- `DEPTH`, default 2: entries per channel FIFO; a power of two, ≥ 2.

- `clk`  in  1  Single clock; all state is updated on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `in`  in  WIDTH  Input data.
- `sel`  in  2  Destination channel: 0 = a, 1 = b, 2 = c, 3 = d.
- `valid`  in  1  Input beat present.
- `ready`  out  1  Demux can accept the beat.
- `a`, `b`, `c`, `d`  out  WIDTH  Channel head data.
- `out_valid`  out  4  Per-channel head valid; bit 0 = a … bit 3 = d.
- `out_ready`  in  4  Per-channel consumer ready; same bit order as `out_valid`.

## Operation
- **Accept:** an input beat is accepted on a rising edge where `valid && ready`. It is pushed into FIFO[`sel`].
- **Ready:** `ready` = !full[`sel`], evaluated whether or not `valid` is high.
  - `ready` must have no combinational path from `out_ready`.
  - A full channel cannot accept a write in the same cycle it pops.
- **Pop:** channel k pops on a rising edge where `out_valid[k] && out_ready[k]`.
- **Channel outputs:**
  - `out_valid[k]` = (count_k != 0).
  - Data output k = mem_k[rd_ptr_k], driven straight from the FIFO storage.
- **Pointers:** `log2(DEPTH)+1` bits with natural wrap. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- **Simultaneous push and pop on one channel:** count is unchanged and both pointers advance. This is legal whenever that channel is not full.
- **Ordering:**
  - Per channel: strictly in order.
  - Across channels: no ordering; a stalled channel never blocks other channels, only beats addressed to it.
- **Reset:** `reset` low asynchronously clears all pointers and counts and zeroes all storage. While reset is asserted:
  - `out_valid` = 4'b0.
  - `a`, `b`, `c`, `d` = 0.
  - `ready` = 1.
- **Reset mid-operation:** all buffered beats are discarded with no partial pops. Normal operation resumes on the first rising edge after `reset` is deasserted.
- **Invalid inputs:** `sel` and `in` are don't-care when `valid` is low; no state changes.

## Timing
- **Latency:** a beat accepted at edge N into an empty channel k shows `out_valid[k]` = 1 with its data after edge N, i.e. in cycle N+1.
- **Throughput:** one beat per cycle into any channel that is not full. With a consumer that is always ready, a channel sustains one beat per cycle.
- **Full assertion:** a channel becomes full DEPTH accepted beats after its last pop. `ready` for that `sel` drops in the cycle after the filling edge.
- **Full release:** `ready` recovers in the cycle after the first pop from the full channel.
- **Head-of-line stall:** a beat held on `valid` while `ready` = 0 must keep `in` and `sel` stable until accepted. This is the standard valid/ready rule, and the bench asserts it.

## Structure
- **Shared package `demux_pkg`:**
  - `NUM_CH` = 4.
  - `typedef logic [1:0] sel_t`.
  - `enum {CH_A, CH_B, CH_C, CH_D}` for channel indexing.
- **Sub-module `demux_chan_fifo`**, parameterised by `WIDTH` and `DEPTH`:
  - Ports: push, push_data, full, pop, head_data, head_valid, plus `clk` and `reset`.
  - Instantiated four times in a generate loop.
- **Top level:** the `sel` decode for push enables, the `ready` mux, and the output bit packing.

## Test plan
- **Reset:** hold `reset` low for 2 cycles with `valid` = 1 → `out_valid` = 0, `a`..`d` = 0, `ready` = 1. Releasing reset leaves all FIFOs empty.
- **Single route:** push `in` = 2'b10 with `sel` = 2 and `out_ready` = 4'b1111 → one cycle later `out_valid` = 4'b0100 and `c` = 2'b10, then `out_valid` returns to 0 after the pop.
- **Fill and backpressure:** with `out_ready` = 0, push 1, 2, 3 to `sel` = 0.
  - First two beats are accepted; `ready` = 0 for the third.
  - Raise `out_ready[0]` → `a` presents 1, then 2, then 3, in order.
  - `ready` reasserts the cycle after the first pop.
- **Channel independence:** with channel b full and `out_ready[1]` = 0, alternate `sel` = 1 and `sel` = 3 → `ready` = 0 only for `sel` = 1; d receives every beat sent to it.
- **Simultaneous push and pop:** channel a holds one entry, `out_ready[0]` = 1, and a beat is pushed to `sel` = 0 every cycle for 8 cycles → count stays 1, `ready` stays 1, all 8 values arrive in order.
- **Reset mid-stream:** assert `reset` while channels a and c each hold 2 entries → `out_valid` clears immediately with no clock edge; nothing from before reset appears after release.
